cond_unit: RTL and testbench
============================

COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the squash counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream operation valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation this cycle.
REQ-006 SHALL have port cond  input  4  condition field of the operation.
REQ-007 SHALL have port flags_in  input  4  ALU flags in {Z,N,C,V} order, bit3=Z, bit0=V.
REQ-008 SHALL have port flag_write  input  1  operation requests a flag update.
REQ-009 SHALL have port reg_write  input  1  operation requests a register write.
REQ-010 SHALL have port mem_write  input  1  operation requests a memory write.
REQ-011 SHALL have port out_valid  output  1  output stage holds an operation.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the output stage.
REQ-013 SHALL have port cond_ex  output  1  registered condition-pass result of the held operation.
REQ-014 SHALL have port reg_write_q, mem_write_q  output  1 each  requests gated by cond_ex.
REQ-015 SHALL have port flags_q  output  4  architectural flags {Z,N,C,V}.
REQ-016 SHALL have port illegal  output  1  held operation used cond=4'b1111.
REQ-017 SHALL have port squash_cnt  output  CNT_W  count of accepted operations that failed their condition.

Function
REQ-018 Accept SHALL occur when in_valid & in_ready; in_ready = ~out_valid | out_ready (one-entry output register, no combinational in_valid->in_ready path).
REQ-019 Condition SHALL be evaluated against flags_q as it stands in the accept cycle: 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V; 8 HI C&~Z; 9 LS ~C|Z; 10 GE N==V; 11 LT N!=V; 12 GT ~Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 fail, illegal=1.
REQ-020 On accept, output stage SHALL load cond_ex, reg_write_q=reg_write&pass, mem_write_q=mem_write&pass, illegal; latency 1 cycle to out_valid.
REQ-021 On accept with flag_write & pass, flags_q SHALL take flags_in at that edge; otherwise flags_q SHALL hold.
REQ-022 Back-to-back accepts SHALL see the flags written by the preceding accepted operation (no bypass of flags_in into evaluation).
REQ-023 Output stage SHALL hold all outputs stable while out_valid & ~out_ready.
REQ-024 out_valid SHALL clear on out_ready with no accept; simultaneous drain and accept SHALL reload with out_valid remaining 1.
REQ-025 squash_cnt SHALL increment by 1 on each accept whose condition fails (including cond=15) and SHALL saturate at all-ones.
REQ-026 When out_valid=0, reg_write_q, mem_write_q, cond_ex and illegal SHALL be 0.

Reset
REQ-027 Reset SHALL asynchronously force out_valid=0, cond_ex=0, reg_write_q=0, mem_write_q=0, illegal=0, flags_q=4'b0000, squash_cnt=0.
REQ-028 Reset asserted mid-operation SHALL discard the held operation without a flag update; in_ready=1 from the first edge after deassertion.

Structure
REQ-029 Shared package cond_pkg SHALL hold the cond_e enum (EQ..AL, NV=15) and flag bit index constants Z_BIT=3, N_BIT=2, C_BIT=1, V_BIT=0.
REQ-030 Condition decode SHALL be a combinational sub-module cond_eval (cond, flags -> pass, illegal) instantiated once.

Verification
REQ-031 Reset, then cond=14, flag_write=1, flags_in=4'b1000, reg_write=1 -> next cycle out_valid=1, cond_ex=1, reg_write_q=1, flags_q=4'b1000.
REQ-032 flags_q=4'b1000, accept cond=1 (NE), mem_write=1, flag_write=1, flags_in=4'b0100 -> cond_ex=0, mem_write_q=0, flags_q stays 4'b1000, squash_cnt=1.
REQ-033 Back-to-back: cycle0 cond=14 flag_write=1 flags_in=4'b0101 (N=1,V=1); cycle1 cond=10 (GE) -> cycle-1 op cond_ex=1; cond=11 (LT) instead -> cond_ex=0.
REQ-034 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 with in_valid=1 -> new op loaded, out_valid stays 1.
REQ-035 cond=15 with reg_write=1 -> illegal=1, reg_write_q=0, squash_cnt+1; 300 failing accepts with CNT_W=8 -> squash_cnt=255.
REQ-036 reset asserted asynchronously while out_valid=1 and flags_q=4'b0110 -> out_valid=0 and flags_q=4'b0000 immediately, before next clk edge.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared condition-code definitions: cond field encoding and flag bit positions.
// No logic; types and constants only.
// Imported by every file of the condition unit.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'd0,
    NE = 4'd1,
    CS = 4'd2,
    CC = 4'd3,
    MI = 4'd4,
    PL = 4'd5,
    VS = 4'd6,
    VC = 4'd7,
    HI = 4'd8,
    LS = 4'd9,
    GE = 4'd10,
    LT = 4'd11,
    GT = 4'd12,
    LE = 4'd13,
    AL = 4'd14,
    NV = 4'd15
  } cond_e;

  // Flag vector is {Z,N,C,V}
  localparam int Z_BIT = 3;
  localparam int N_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

endpackage

// File: rtl/cond_eval.sv
// Condition decode: cond field + flags -> pass / illegal.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no state.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass,
  output logic       illegal
);

  logic z, n, c, v;

  assign z = flags[Z_BIT];
  assign n = flags[N_BIT];
  assign c = flags[C_BIT];
  assign v = flags[V_BIT];

  // Decode the condition; NV never passes and is flagged illegal
  always_comb begin
    pass    = 1'b0;
    illegal = 1'b0;
    case (cond_e'(cond))
      EQ: pass = z;
      NE: pass = ~z;
      CS: pass = c;
      CC: pass = ~c;
      MI: pass = n;
      PL: pass = ~n;
      VS: pass = v;
      VC: pass = ~v;
      HI: pass = c & ~z;
      LS: pass = ~c | z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = ~z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      NV: illegal = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: evaluates cond against architectural flags, gates writes.
// Latency: 1 cycle from accept to out_valid; flags update at the accept edge.
// Backpressure: one-entry output register, in_ready = ~out_valid | out_ready.
module cond_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cond,
  input  logic [3:0]       flags_in,
  input  logic             flag_write,
  input  logic             reg_write,
  input  logic             mem_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             cond_ex,
  output logic             reg_write_q,
  output logic             mem_write_q,
  output logic [3:0]       flags_q,
  output logic             illegal,
  output logic [CNT_W-1:0] squash_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic pass;
  logic illegal_d;
  logic accept;

  // Evaluation always sees the registered flags, never flags_in
  cond_eval u_cond_eval (
    .cond    (cond),
    .flags   (flags_q),
    .pass    (pass),
    .illegal (illegal_d)
  );

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Output stage: load on accept, clear to zero when drained without reload
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      cond_ex     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      illegal     <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      cond_ex     <= pass;
      reg_write_q <= reg_write & pass;
      mem_write_q <= mem_write & pass;
      illegal     <= illegal_d;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
      cond_ex     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      illegal     <= 1'b0;
    end
  end

  // Architectural flags: written only by an accepted, passing flag-setting op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (accept && flag_write && pass) begin
      flags_q <= flags_in;
    end
  end

  // Saturating count of accepted ops whose condition failed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      squash_cnt <= '0;
    end else if (accept && !pass && squash_cnt != CNT_MAX) begin
      squash_cnt <= squash_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit with hand-computed expected values.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Ends with a single summary line.
module tb_cond_unit;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] cond;
  logic [3:0] flags_in;
  logic       flag_write;
  logic       reg_write;
  logic       mem_write;
  logic       out_valid;
  logic       out_ready;
  logic       cond_ex;
  logic       reg_write_q;
  logic       mem_write_q;
  logic [3:0] flags_q;
  logic       illegal;
  logic [7:0] squash_cnt;

  int checks;
  int failures;

  cond_unit #(.CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cond        (cond),
    .flags_in    (flags_in),
    .flag_write  (flag_write),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .cond_ex     (cond_ex),
    .reg_write_q (reg_write_q),
    .mem_write_q (mem_write_q),
    .flags_q     (flags_q),
    .illegal     (illegal),
    .squash_cnt  (squash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic fw, input logic [3:0] fi,
                       input logic rw, input logic mw);
    in_valid   = 1'b1;
    cond       = c;
    flag_write = fw;
    flags_in   = fi;
    reg_write  = rw;
    mem_write  = mw;
  endtask

  // Flags 4'b0110 (Z=0 N=1 C=1 V=0): cond -> expected pass
  logic [3:0] tbl_cond [12] = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13,
                                4'd2, 4'd3, 4'd6,  4'd7,  4'd0,  4'd1};
  logic       tbl_pass [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                                1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int exp_sq;
    checks   = 0;
    failures = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    cond       = 4'd0;
    flags_in   = 4'd0;
    flag_write = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    out_ready  = 1'b1;

    step();
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_flags", {28'd0, flags_q}, 32'd0);
    check("rst_squash", {24'd0, squash_cnt}, 32'd0);
    check("rst_cond_ex", {31'd0, cond_ex}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // AL with flag write
    drive(4'd14, 1'b1, 4'b1000, 1'b1, 1'b0);
    step();
    check("al_out_valid", {31'd0, out_valid}, 32'd1);
    check("al_cond_ex", {31'd0, cond_ex}, 32'd1);
    check("al_reg_write_q", {31'd0, reg_write_q}, 32'd1);
    check("al_mem_write_q", {31'd0, mem_write_q}, 32'd0);
    check("al_flags", {28'd0, flags_q}, 32'h8);
    check("al_illegal", {31'd0, illegal}, 32'd0);

    // NE with Z=1 fails: no mem write, no flag update
    drive(4'd1, 1'b1, 4'b0100, 1'b0, 1'b1);
    step();
    check("ne_cond_ex", {31'd0, cond_ex}, 32'd0);
    check("ne_mem_write_q", {31'd0, mem_write_q}, 32'd0);
    check("ne_flags_hold", {28'd0, flags_q}, 32'h8);
    check("ne_squash", {24'd0, squash_cnt}, 32'd1);
    check("ne_out_valid", {31'd0, out_valid}, 32'd1);

    // Back-to-back: AL writes N=1,V=1, then GE sees it
    drive(4'd14, 1'b1, 4'b0101, 1'b0, 1'b0);
    step();
    check("b2b_flags", {28'd0, flags_q}, 32'h5);
    drive(4'd10, 1'b0, 4'b0000, 1'b1, 1'b0);
    step();
    check("b2b_ge", {31'd0, cond_ex}, 32'd1);
    check("b2b_ge_rw", {31'd0, reg_write_q}, 32'd1);
    drive(4'd11, 1'b0, 4'b0000, 1'b1, 1'b0);
    step();
    check("b2b_lt", {31'd0, cond_ex}, 32'd0);
    check("b2b_lt_squash", {24'd0, squash_cnt}, 32'd2);

    // EQ with Z=0 in flags_q must fail even though flags_in carries Z=1
    drive(4'd0, 1'b1, 4'b1000, 1'b0, 1'b0);
    step();
    check("nobypass_cond_ex", {31'd0, cond_ex}, 32'd0);
    check("nobypass_flags", {28'd0, flags_q}, 32'h5);
    check("nobypass_squash", {24'd0, squash_cnt}, 32'd3);

    // Drain with no new op
    in_valid = 1'b0;
    step();
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    check("drain_cond_ex", {31'd0, cond_ex}, 32'd0);
    check("drain_reg_write_q", {31'd0, reg_write_q}, 32'd0);
    check("drain_in_ready", {31'd0, in_ready}, 32'd1);

    // Stall: MI passes (N=1), then hold for 3 cycles
    drive(4'd4, 1'b0, 4'b0000, 1'b1, 1'b1);
    step();
    check("stall_load_rw", {31'd0, reg_write_q}, 32'd1);
    drive(4'd5, 1'b0, 4'b0000, 1'b0, 1'b1);
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_cond_ex", {31'd0, cond_ex}, 32'd1);
      check("stall_rw", {31'd0, reg_write_q}, 32'd1);
      check("stall_mw", {31'd0, mem_write_q}, 32'd1);
    end
    check("stall_squash", {24'd0, squash_cnt}, 32'd3);
    out_ready = 1'b1;
    #1;
    check("reload_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("reload_out_valid", {31'd0, out_valid}, 32'd1);
    check("reload_cond_ex", {31'd0, cond_ex}, 32'd0);
    check("reload_mw", {31'd0, mem_write_q}, 32'd0);
    check("reload_rw", {31'd0, reg_write_q}, 32'd0);
    check("reload_squash", {24'd0, squash_cnt}, 32'd4);

    // Illegal cond with reg and flag write requested
    drive(4'd15, 1'b1, 4'b1111, 1'b1, 1'b0);
    step();
    check("nv_illegal", {31'd0, illegal}, 32'd1);
    check("nv_rw", {31'd0, reg_write_q}, 32'd0);
    check("nv_cond_ex", {31'd0, cond_ex}, 32'd0);
    check("nv_squash", {24'd0, squash_cnt}, 32'd5);
    check("nv_flags_hold", {28'd0, flags_q}, 32'h5);

    // Condition table against flags 4'b0110
    drive(4'd14, 1'b1, 4'b0110, 1'b0, 1'b0);
    step();
    check("tbl_flags", {28'd0, flags_q}, 32'h6);
    check("tbl_illegal_clr", {31'd0, illegal}, 32'd0);
    exp_sq = 5;
    for (int i = 0; i < 12; i++) begin
      drive(tbl_cond[i], 1'b0, 4'b0000, 1'b0, 1'b1);
      step();
      if (!tbl_pass[i]) exp_sq++;
      check($sformatf("tbl_cond%0d", tbl_cond[i]), {31'd0, cond_ex}, {31'd0, tbl_pass[i]});
      check($sformatf("tbl_mw%0d", tbl_cond[i]), {31'd0, mem_write_q}, {31'd0, tbl_pass[i]});
    end
    check("tbl_squash", {24'd0, squash_cnt}, exp_sq[31:0]);

    // Async reset while holding an op with flags 4'b0110
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_flags", {28'd0, flags_q}, 32'd0);
    check("arst_squash", {24'd0, squash_cnt}, 32'd0);
    check("arst_mw", {31'd0, mem_write_q}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);

    // Saturation: 300 failing accepts
    drive(4'd15, 1'b0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step();
    check("sat_squash", {24'd0, squash_cnt}, 32'd255);
    check("sat_illegal", {31'd0, illegal}, 32'd1);
    step();
    check("sat_hold", {24'd0, squash_cnt}, 32'd255);

    in_valid = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
